// File: rtl/upstream_adp_if.sv
// upstream_adp_if
//  Bundles the two buses of the upstream adaptor:
//   - event buffer side: ev_avail/ev_done/hdr_err handshake and the rd_en/rd_addr/rd_data read port
//   - AXI-Stream side: TVALID/TREADY/TDATA/TSTRB/TKEEP/TLAST/TID
//  master: the adaptor (drives strobes, read address and the stream)
//  slave : the environment (buffer + stream sink)
interface upstream_adp_if #(
  parameter int ADDR_WIDTH = 10
);
  // event buffer side
  logic                  ev_avail;
  logic                  ev_done;
  logic                  hdr_err;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [127:0]          rd_data;
  // AXI-Stream side
  logic                  TVALID;
  logic                  TREADY;
  logic [127:0]          TDATA;
  logic [15:0]           TSTRB;
  logic [15:0]           TKEEP;
  logic                  TLAST;
  logic [10:0]           TID;

  modport master (
    input  ev_avail, rd_data, TREADY,
    output ev_done, hdr_err, rd_en, rd_addr,
    output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID
  );

  modport slave (
    output ev_avail, rd_data, TREADY,
    input  ev_done, hdr_err, rd_en, rd_addr,
    input  TVALID, TDATA, TSTRB, TKEEP, TLAST, TID
  );
endinterface

// File: rtl/upstream_adp.sv
// upstream_adp
//  Reads a completed GEP event out of the event buffer and transmits it as AXI-Stream.
//  Buffer layout: word 0 = header ([20:10] BCID, [ADDR_WIDTH-1:0] beat count N),
//  words 1..N = data beats. N==0 is rejected with hdr_err.
// Ports
//  clk      clock
//  ARESETn  asynchronous reset, active low
//  bus      upstream_adp_if.master: ev_avail/ev_done/hdr_err, rd_en/rd_addr/rd_data,
//           TVALID/TREADY/TDATA/TSTRB/TKEEP/TLAST/TID
module upstream_adp #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            ARESETn,
  upstream_adp_if.master  bus
);

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    HCAP   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t                          state_reg, state_next;
  logic [10:0]                     bcid_reg;
  logic [ADDR_WIDTH-1:0]           n_reg;
  // one bit wider than the address so that "next address = N+1" is representable
  // when N is all ones, which keeps the read address from ever wrapping to 0
  logic [ADDR_WIDTH:0]             rd_ptr_reg;
  logic [ADDR_WIDTH-1:0]           head_idx_reg;
  logic [CNT_W-1:0]                count_reg;
  logic                            dvalid_reg;   // a data read issued last cycle returns now
  logic [FIFO_DEPTH-1:0][127:0]    slot_reg;
  logic [FIFO_DEPTH-1:0][127:0]    slot_next;

  logic                            tvalid;
  logic                            tlast;
  logic                            pop;
  logic                            push;
  logic [CNT_W-1:0]                wr_pos;
  logic [2:0]                      commit;
  logic                            remain;
  logic                            issue;
  logic                            rd_en_c;
  logic [ADDR_WIDTH-1:0]           rd_addr_c;
  logic                            ev_done_c;
  logic                            hdr_err_c;

  // FIFO head is a register, so TVALID/TDATA/TLAST come straight from flops
  assign tvalid = (count_reg != '0);
  assign tlast  = tvalid && (head_idx_reg == n_reg);
  assign pop    = tvalid && bus.TREADY;
  assign push   = dvalid_reg;
  // slot that the returning word lands in, after this cycle's pop shifts the queue
  assign wr_pos = count_reg - CNT_W'(pop);
  // words already committed to the FIFO (stored or in flight) once this cycle's pop is taken
  assign commit = 3'(count_reg) + 3'(dvalid_reg) - 3'(pop);
  assign remain = (rd_ptr_reg <= {1'b0, n_reg});

  // per-slot next value: returning word lands at wr_pos, otherwise shift toward head on pop
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    if (gi < FIFO_DEPTH - 1) begin : g_shift
      assign slot_next[gi] = (push && wr_pos == CNT_W'(gi))            ? bus.rd_data :
                             (pop && CNT_W'(gi + 1) < count_reg)       ? slot_reg[gi + 1] :
                                                                         slot_reg[gi];
    end else begin : g_tail
      assign slot_next[gi] = (push && wr_pos == CNT_W'(gi)) ? bus.rd_data : slot_reg[gi];
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en_c    = 1'b0;
    rd_addr_c  = '0;
    ev_done_c  = 1'b0;
    hdr_err_c  = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.ev_avail) state_next = HDR;
      end
      HDR: begin
        rd_en_c    = 1'b1;
        rd_addr_c  = '0;
        state_next = HCAP;
      end
      HCAP: begin
        state_next = (bus.rd_data[ADDR_WIDTH-1:0] == '0) ? ERR : STREAM;
      end
      STREAM: begin
        if (remain && commit < 3'd2) begin
          issue     = 1'b1;
          rd_en_c   = 1'b1;
          rd_addr_c = rd_ptr_reg[ADDR_WIDTH-1:0];
        end
        if (pop && tlast) state_next = DONE;
      end
      DONE: begin
        // ev_avail is deliberately not looked at here; the producer gets a cycle to drop it
        ev_done_c  = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        hdr_err_c  = 1'b1;
        ev_done_c  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      bcid_reg     <= '0;
      n_reg        <= '0;
      rd_ptr_reg   <= '0;
      head_idx_reg <= '0;
      count_reg    <= '0;
      dvalid_reg   <= 1'b0;
      slot_reg     <= '0;
    end else begin
      if (state_reg == HCAP) begin
        bcid_reg     <= bus.rd_data[20:10];
        n_reg        <= bus.rd_data[ADDR_WIDTH-1:0];
        rd_ptr_reg   <= (ADDR_WIDTH + 1)'(1);
        head_idx_reg <= ADDR_WIDTH'(1);
      end else begin
        if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (pop) head_idx_reg <= head_idx_reg + 1'b1;
      end
      dvalid_reg <= issue;
      count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
      slot_reg   <= slot_next;
    end
  end

  assign bus.rd_en   = rd_en_c;
  assign bus.rd_addr = rd_addr_c;
  assign bus.ev_done = ev_done_c;
  assign bus.hdr_err = hdr_err_c;
  assign bus.TVALID  = tvalid;
  assign bus.TDATA   = slot_reg[0];
  assign bus.TLAST   = tlast;
  assign bus.TID     = bcid_reg;
  assign bus.TSTRB   = 16'hFFFF;
  assign bus.TKEEP   = 16'hFFFF;

endmodule

// File: tb/tb_upstream_adp.sv
`timescale 1ns/1ps
// tb_upstream_adp
//  Directed tests for upstream_adp: event buffer model with one-cycle read latency,
//  a negedge monitor that logs reads, beats and pulses, and one task per scenario.
module tb_upstream_adp;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic ARESETn = 1'b0;
  always #5 clk = ~clk;

  upstream_adp_if #(.ADDR_WIDTH(AW)) bus ();
  upstream_adp #(.ADDR_WIDTH(AW)) dut (.clk(clk), .ARESETn(ARESETn), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event buffer: data valid the cycle after rd_en
  logic [127:0] mem [1024];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // monitor logs
  int           rd_addr_q[$];
  int           rd_cyc_q[$];
  int           bt_cyc_q[$];
  logic [127:0] bt_data_q[$];
  logic         bt_last_q[$];
  logic [10:0]  bt_tid_q[$];
  int           done_cyc_q[$];
  int           err_cyc_q[$];
  int           tvalid_cnt = 0;
  int           stab_viol = 0;
  int           occ_viol = 0;
  int           out_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic         prev_last = 1'b0;
  logic [10:0]  prev_tid = '0;

  always @(negedge clk) begin : mon
    int nxt;
    if (!ARESETn) begin
      out_cnt    <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        rd_addr_q.push_back(int'(bus.rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (bus.TVALID) tvalid_cnt <= tvalid_cnt + 1;
      if (prev_stall && (!bus.TVALID || bus.TDATA !== prev_data ||
                         bus.TLAST !== prev_last || bus.TID !== prev_tid))
        stab_viol <= stab_viol + 1;
      if (bus.TVALID && bus.TREADY) begin
        bt_cyc_q.push_back(cyc);
        bt_data_q.push_back(bus.TDATA);
        bt_last_q.push_back(bus.TLAST);
        bt_tid_q.push_back(bus.TID);
      end
      if (bus.ev_done) done_cyc_q.push_back(cyc);
      if (bus.hdr_err) err_cyc_q.push_back(cyc);
      // data words read but not yet transferred = FIFO occupancy + in-flight
      nxt = out_cnt + ((bus.rd_en && bus.rd_addr != '0) ? 1 : 0)
                    - ((bus.TVALID && bus.TREADY) ? 1 : 0);
      out_cnt <= nxt;
      if (nxt > 2) occ_viol <= occ_viol + 1;
      prev_stall <= bus.TVALID && !bus.TREADY;
      prev_data  <= bus.TDATA;
      prev_last  <= bus.TLAST;
      prev_tid   <= bus.TID;
    end
  end

  function automatic logic [127:0] word(input int ev, input int i);
    return {32'hDA7A_0000 + 32'(ev), 32'(i) ^ 32'hFFFF_FFFF, 32'h1234_5678, 32'(i)};
  endfunction

  function automatic logic [127:0] make_hdr(input int n, input int bcid);
    // junk in the upper bits must be ignored
    return {64'hDEAD_BEEF_CAFE_F00D, 43'h2A5_A5A5_A5A5, 11'(bcid), 10'(n)};
  endfunction

  task automatic load_event(input int ev, input int n, input int bcid);
    mem[0] = make_hdr(n, bcid);
    for (int i = 1; i <= n; i++) mem[i] = word(ev, i);
  endtask

  function automatic logic ready_fn(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      default: return k >= 15;
    endcase
  endfunction

  // Presents ev_avail and waits (bounded) for ev_done; t0 = cycle where IDLE sees ev_avail.
  task automatic run_event(input int mode, input bit drop_avail, input bit keep_avail,
                           input bit already, input int budget, output int t0, output bit ok);
    int d0;
    d0 = done_cyc_q.size();
    ok = 1'b0;
    if (!already) begin
      @(posedge clk); #1;
    end
    bus.ev_avail = 1'b1;
    t0 = cyc;
    bus.TREADY = ready_fn(mode, 0);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      bus.TREADY = ready_fn(mode, k);
      if (drop_avail) bus.ev_avail = 1'b0;
      if (done_cyc_q.size() > d0) begin
        ok = 1'b1;
        if (!keep_avail) bus.ev_avail = 1'b0;
        break;
      end
    end
    if (!ok) bus.ev_avail = 1'b0;
  endtask

  task automatic test_reset();
    logic [153:0] obs;
    bus.ev_avail = 1'b0;
    bus.TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.TVALID, bus.TLAST, bus.rd_en, bus.ev_done, bus.hdr_err, bus.rd_addr, bus.TID, bus.TDATA};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", obs);
    end
    vectors++;
    if ({bus.TSTRB, bus.TKEEP} !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL strb_keep: got %h, want ffffffff", {bus.TSTRB, bus.TKEEP});
    end
    ARESETn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.rd_en, bus.TVALID, bus.ev_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_quiet: got %b, want 000", {bus.rd_en, bus.TVALID, bus.ev_done});
    end
  endtask

  task automatic test_basic();
    int t0, r0, b0, d0, e0;
    bit ok;
    load_event(1, 3, 'h2A5);
    r0 = rd_addr_q.size(); b0 = bt_cyc_q.size(); d0 = done_cyc_q.size(); e0 = err_cyc_q.size();
    run_event(0, 1'b0, 1'b0, 1'b0, 40, t0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_timeout: got no ev_done, want ev_done within 40 cycles"); end
    vectors++;
    if (rd_addr_q.size() - r0 !== 4) begin miscompares++; $display("FAIL basic_nreads: got %0d, want 4", rd_addr_q.size() - r0); end
    for (int i = 0; i < 4 && r0 + i < rd_addr_q.size(); i++) begin
      vectors++;
      if (rd_addr_q[r0 + i] !== i) begin miscompares++; $display("FAIL basic_rd_addr[%0d]: got %0d, want %0d", i, rd_addr_q[r0 + i], i); end
      vectors++;
      if (rd_cyc_q[r0 + i] - t0 !== ((i == 0) ? 1 : i + 2)) begin
        miscompares++;
        $display("FAIL basic_rd_cycle[%0d]: got %0d, want %0d", i, rd_cyc_q[r0 + i] - t0, (i == 0) ? 1 : i + 2);
      end
    end
    vectors++;
    if (bt_cyc_q.size() - b0 !== 3) begin miscompares++; $display("FAIL basic_nbeats: got %0d, want 3", bt_cyc_q.size() - b0); end
    for (int i = 0; i < 3 && b0 + i < bt_cyc_q.size(); i++) begin
      vectors++;
      if ({bt_data_q[b0 + i], bt_tid_q[b0 + i], bt_last_q[b0 + i]} !== {word(1, i + 1), 11'h2A5, (i == 2)}) begin
        miscompares++;
        $display("FAIL basic_beat[%0d]: got %h/%h/%b, want %h/2a5/%b", i, bt_data_q[b0 + i], bt_tid_q[b0 + i], bt_last_q[b0 + i], word(1, i + 1), (i == 2));
      end
      vectors++;
      if (bt_cyc_q[b0 + i] - t0 !== 5 + i) begin miscompares++; $display("FAIL basic_beat_cycle[%0d]: got %0d, want %0d", i, bt_cyc_q[b0 + i] - t0, 5 + i); end
    end
    vectors++;
    if (done_cyc_q.size() - d0 !== 1 || done_cyc_q[d0] - t0 !== 8) begin
      miscompares++;
      $display("FAIL basic_done: got %0d pulses, first at +%0d, want 1 pulse at +8", done_cyc_q.size() - d0, done_cyc_q[d0] - t0);
    end
    vectors++;
    if (err_cyc_q.size() - e0 !== 0) begin miscompares++; $display("FAIL basic_no_err: got %0d, want 0", err_cyc_q.size() - e0); end
  endtask

  task automatic test_stall();
    int t0, r0, b0, d0, s0, o0;
    bit ok;
    load_event(2, 5, 'h155);
    r0 = rd_addr_q.size(); b0 = bt_cyc_q.size(); d0 = done_cyc_q.size(); s0 = stab_viol; o0 = occ_viol;
    // ev_avail is dropped right after the event starts; the event must still complete
    run_event(1, 1'b1, 1'b0, 1'b0, 60, t0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_timeout: got no ev_done, want ev_done within 60 cycles"); end
    vectors++;
    if (rd_addr_q.size() - r0 !== 6) begin miscompares++; $display("FAIL stall_nreads: got %0d, want 6", rd_addr_q.size() - r0); end
    for (int i = 0; i < 6 && r0 + i < rd_addr_q.size(); i++) begin
      vectors++;
      if (rd_addr_q[r0 + i] !== i) begin miscompares++; $display("FAIL stall_rd_addr[%0d]: got %0d, want %0d", i, rd_addr_q[r0 + i], i); end
    end
    vectors++;
    if (bt_cyc_q.size() - b0 !== 5) begin miscompares++; $display("FAIL stall_nbeats: got %0d, want 5", bt_cyc_q.size() - b0); end
    for (int i = 0; i < 5 && b0 + i < bt_cyc_q.size(); i++) begin
      vectors++;
      if ({bt_data_q[b0 + i], bt_tid_q[b0 + i], bt_last_q[b0 + i]} !== {word(2, i + 1), 11'h155, (i == 4)}) begin
        miscompares++;
        $display("FAIL stall_beat[%0d]: got %h/%h/%b, want %h/155/%b", i, bt_data_q[b0 + i], bt_tid_q[b0 + i], bt_last_q[b0 + i], word(2, i + 1), (i == 4));
      end
    end
    vectors++;
    if (stab_viol - s0 !== 0) begin miscompares++; $display("FAIL stall_stability: got %0d unstable stalled cycles, want 0", stab_viol - s0); end
    vectors++;
    if (occ_viol - o0 !== 0) begin miscompares++; $display("FAIL stall_occupancy: got %0d cycles above 2 words, want 0", occ_viol - o0); end
    vectors++;
    if (done_cyc_q.size() - d0 !== 1) begin miscompares++; $display("FAIL stall_done: got %0d, want 1", done_cyc_q.size() - d0); end
  endtask

  task automatic test_hdr_err();
    int t0, r0, d0, e0, v0;
    bit ok;
    load_event(3, 0, 'h011);
    r0 = rd_addr_q.size(); d0 = done_cyc_q.size(); e0 = err_cyc_q.size(); v0 = tvalid_cnt;
    run_event(0, 1'b0, 1'b0, 1'b0, 20, t0, ok);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL err_timeout: got no ev_done, want ev_done within 20 cycles"); end
    vectors++;
    if (err_cyc_q.size() - e0 !== 1 || done_cyc_q.size() - d0 !== 1) begin
      miscompares++;
      $display("FAIL err_pulses: got hdr_err %0d ev_done %0d, want 1 and 1", err_cyc_q.size() - e0, done_cyc_q.size() - d0);
    end
    vectors++;
    if (err_cyc_q[e0] - t0 !== 3 || done_cyc_q[d0] - t0 !== 3) begin
      miscompares++;
      $display("FAIL err_cycle: got hdr_err +%0d ev_done +%0d, want both +3", err_cyc_q[e0] - t0, done_cyc_q[d0] - t0);
    end
    vectors++;
    if (tvalid_cnt - v0 !== 0) begin miscompares++; $display("FAIL err_no_tvalid: got %0d valid cycles, want 0", tvalid_cnt - v0); end
    vectors++;
    if (rd_addr_q.size() - r0 !== 1) begin miscompares++; $display("FAIL err_reads: got %0d, want 1", rd_addr_q.size() - r0); end
  endtask

  task automatic test_single_stall();
    int t0, r0, b0, d0, s0, v0;
    bit ok;
    load_event(4, 1, 'h4C3);
    r0 = rd_addr_q.size(); b0 = bt_cyc_q.size(); d0 = done_cyc_q.size(); s0 = stab_viol; v0 = tvalid_cnt;
    run_event(2, 1'b0, 1'b0, 1'b0, 40, t0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL single_timeout: got no ev_done, want ev_done within 40 cycles"); end
    vectors++;
    if (bt_cyc_q.size() - b0 !== 1) begin miscompares++; $display("FAIL single_nbeats: got %0d, want 1", bt_cyc_q.size() - b0); end
    vectors++;
    if ({bt_data_q[b0], bt_tid_q[b0], bt_last_q[b0]} !== {word(4, 1), 11'h4C3, 1'b1}) begin
      miscompares++;
      $display("FAIL single_beat: got %h/%h/%b, want %h/4c3/1", bt_data_q[b0], bt_tid_q[b0], bt_last_q[b0], word(4, 1));
    end
    vectors++;
    if (bt_cyc_q[b0] - t0 !== 15) begin miscompares++; $display("FAIL single_xfer_cycle: got +%0d, want +15", bt_cyc_q[b0] - t0); end
    vectors++;
    if (tvalid_cnt - v0 !== 11) begin miscompares++; $display("FAIL single_valid_cycles: got %0d, want 11", tvalid_cnt - v0); end
    vectors++;
    if (stab_viol - s0 !== 0) begin miscompares++; $display("FAIL single_stability: got %0d, want 0", stab_viol - s0); end
    vectors++;
    if (done_cyc_q[d0] - t0 !== 16) begin miscompares++; $display("FAIL single_done_cycle: got +%0d, want +16", done_cyc_q[d0] - t0); end
    vectors++;
    if (rd_addr_q.size() - r0 !== 2) begin miscompares++; $display("FAIL single_reads: got %0d, want 2", rd_addr_q.size() - r0); end
  endtask

  task automatic test_reset_mid();
    int t0, r0, b0, d0;
    bit ok, hit;
    logic [153:0] obs;
    load_event(5, 6, 'h6B1);
    b0 = bt_cyc_q.size(); d0 = done_cyc_q.size();
    @(posedge clk); #1;
    bus.ev_avail = 1'b1;
    bus.TREADY = 1'b1;
    hit = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bt_cyc_q.size() - b0 >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (hit !== 1'b1) begin miscompares++; $display("FAIL rmid_two_beats: got %0d beats, want 2 within 30 cycles", bt_cyc_q.size() - b0); end
    ARESETn = 1'b0;
    bus.ev_avail = 1'b0;
    #1;
    obs = {bus.TVALID, bus.TLAST, bus.rd_en, bus.ev_done, bus.hdr_err, bus.rd_addr, bus.TID, bus.TDATA};
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL rmid_async_clear: got %h, want 0", obs); end
    repeat (2) @(posedge clk);
    #1;
    ARESETn = 1'b1;
    vectors++;
    if (done_cyc_q.size() - d0 !== 0 || bt_cyc_q.size() - b0 !== 2) begin
      miscompares++;
      $display("FAIL rmid_aborted: got ev_done %0d beats %0d, want 0 and 2", done_cyc_q.size() - d0, bt_cyc_q.size() - b0);
    end
    r0 = rd_addr_q.size(); b0 = bt_cyc_q.size(); d0 = done_cyc_q.size();
    run_event(0, 1'b0, 1'b0, 1'b0, 40, t0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL rmid_timeout: got no ev_done, want ev_done within 40 cycles"); end
    vectors++;
    if (rd_addr_q.size() - r0 !== 7) begin miscompares++; $display("FAIL rmid_nreads: got %0d, want 7", rd_addr_q.size() - r0); end
    for (int i = 0; i < 7 && r0 + i < rd_addr_q.size(); i++) begin
      vectors++;
      if (rd_addr_q[r0 + i] !== i) begin miscompares++; $display("FAIL rmid_rd_addr[%0d]: got %0d, want %0d", i, rd_addr_q[r0 + i], i); end
    end
    vectors++;
    if (bt_cyc_q.size() - b0 !== 6) begin miscompares++; $display("FAIL rmid_nbeats: got %0d, want 6", bt_cyc_q.size() - b0); end
    for (int i = 0; i < 6 && b0 + i < bt_cyc_q.size(); i++) begin
      vectors++;
      if ({bt_data_q[b0 + i], bt_tid_q[b0 + i], bt_last_q[b0 + i]} !== {word(5, i + 1), 11'h6B1, (i == 5)}) begin
        miscompares++;
        $display("FAIL rmid_beat[%0d]: got %h/%h/%b, want %h/6b1/%b", i, bt_data_q[b0 + i], bt_tid_q[b0 + i], bt_last_q[b0 + i], word(5, i + 1), (i == 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    int ta, tb, ra, ba, rb, bb, d0;
    bit oka, okb;
    load_event(6, 1023, 'h3C3);
    ra = rd_addr_q.size(); ba = bt_cyc_q.size(); d0 = done_cyc_q.size();
    run_event(0, 1'b0, 1'b1, 1'b0, 1100, ta, oka);
    // we are now in the IDLE cycle after ev_done with ev_avail still high: next event is ready
    load_event(7, 4, 'h0F0);
    rb = rd_addr_q.size(); bb = bt_cyc_q.size();
    run_event(0, 1'b0, 1'b0, 1'b1, 40, tb, okb);
    vectors++;
    if ({oka, okb} !== 2'b11) begin miscompares++; $display("FAIL b2b_timeout: got done flags %b%b, want 11", oka, okb); end
    vectors++;
    if (rb - ra !== 1024) begin miscompares++; $display("FAIL b2b_a_nreads: got %0d, want 1024", rb - ra); end
    for (int i = 0; i < 1024 && ra + i < rb; i++) begin
      vectors++;
      if (rd_addr_q[ra + i] !== i) begin miscompares++; $display("FAIL b2b_a_rd_addr[%0d]: got %0d, want %0d", i, rd_addr_q[ra + i], i); break; end
    end
    vectors++;
    if (bb - ba !== 1023) begin miscompares++; $display("FAIL b2b_a_nbeats: got %0d, want 1023", bb - ba); end
    for (int i = 0; i < 1023 && ba + i < bb; i++) begin
      vectors++;
      if ({bt_data_q[ba + i], bt_tid_q[ba + i], bt_last_q[ba + i]} !== {word(6, i + 1), 11'h3C3, (i == 1022)}) begin
        miscompares++;
        $display("FAIL b2b_a_beat[%0d]: got %h/%h/%b, want %h/3c3/%b", i, bt_data_q[ba + i], bt_tid_q[ba + i], bt_last_q[ba + i], word(6, i + 1), (i == 1022));
        break;
      end
    end
    vectors++;
    if (bt_cyc_q[ba + 1022] - bt_cyc_q[ba] !== 1022) begin
      miscompares++;
      $display("FAIL b2b_a_contiguous: got span %0d, want 1022", bt_cyc_q[ba + 1022] - bt_cyc_q[ba]);
    end
    vectors++;
    if (done_cyc_q[d0] - bt_cyc_q[ba + 1022] !== 1) begin
      miscompares++;
      $display("FAIL b2b_a_done: got +%0d after last beat, want +1", done_cyc_q[d0] - bt_cyc_q[ba + 1022]);
    end
    vectors++;
    if (rd_addr_q.size() - rb !== 5) begin miscompares++; $display("FAIL b2b_b_nreads: got %0d, want 5", rd_addr_q.size() - rb); end
    for (int i = 0; i < 5 && rb + i < rd_addr_q.size(); i++) begin
      vectors++;
      if (rd_addr_q[rb + i] !== i) begin miscompares++; $display("FAIL b2b_b_rd_addr[%0d]: got %0d, want %0d", i, rd_addr_q[rb + i], i); end
    end
    vectors++;
    if (bt_cyc_q.size() - bb !== 4) begin miscompares++; $display("FAIL b2b_b_nbeats: got %0d, want 4", bt_cyc_q.size() - bb); end
    for (int i = 0; i < 4 && bb + i < bt_cyc_q.size(); i++) begin
      vectors++;
      if ({bt_data_q[bb + i], bt_tid_q[bb + i], bt_last_q[bb + i]} !== {word(7, i + 1), 11'h0F0, (i == 3)}) begin
        miscompares++;
        $display("FAIL b2b_b_beat[%0d]: got %h/%h/%b, want %h/0f0/%b", i, bt_data_q[bb + i], bt_tid_q[bb + i], bt_last_q[bb + i], word(7, i + 1), (i == 3));
      end
    end
    vectors++;
    if (bt_cyc_q[bb] - tb !== 5) begin miscompares++; $display("FAIL b2b_b_latency: got +%0d, want +5", bt_cyc_q[bb] - tb); end
    vectors++;
    if (done_cyc_q.size() - d0 !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d, want 2", done_cyc_q.size() - d0); end
  endtask

  initial begin
    bus.ev_avail = 1'b0;
    bus.TREADY = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_hdr_err();
    test_single_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
